// File: rtl/mrd_fsmsink.sv
// Input-side write controller of the mixed-radix DFT memory: takes one
// sop/eop framed stream of dftpts samples and spreads it over 7 RAM banks.
module mrd_fsmsink #(
  parameter int DW = 18,
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    fsm,
  input  logic [AW-1:0] dftpts,
  input  logic          in_sop,
  input  logic          in_eop,
  input  logic          in_valid,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_imag,
  output logic [6:0]    wren,
  output logic [AW-1:0] bank_addr,
  output logic [DW-1:0] wr_real,
  output logic [DW-1:0] wr_imag,
  output logic [AW-1:0] cnt_sink,
  output logic          sink_end,
  output logic          sink_err
);

  localparam logic [2:0] FSM_SINK = 3'd1;

  typedef enum logic [1:0] {IDLE, ARMED, RECV, DONE} state_t;

  state_t        state;
  logic [AW-1:0] n_lat;
  logic [2:0]    bidx;
  logic [AW-1:0] baddr;

  logic          sop_take;
  logic          accept;
  logic [AW-1:0] cur_idx;
  logic [AW-1:0] cur_n;
  logic [2:0]    cur_bidx;
  logic [AW-1:0] cur_baddr;
  logic          is_last;
  logic          short_eop;
  logic [2:0]    nxt_bidx;
  logic [AW-1:0] nxt_baddr;

  // A sop sample always restarts at point 0 with a freshly latched length,
  // so its eop flag is ignored and it can never be a short frame.
  always_comb begin
    sop_take  = in_valid && in_sop && (state == ARMED || state == RECV);
    accept    = sop_take || (in_valid && state == RECV);
    cur_idx   = sop_take ? '0 : cnt_sink;
    cur_n     = sop_take ? dftpts : n_lat;
    cur_bidx  = sop_take ? '0 : bidx;
    cur_baddr = sop_take ? '0 : baddr;
    is_last   = (cur_idx == cur_n - AW'(1));
    short_eop = in_eop && !sop_take && !is_last;
    nxt_bidx  = (cur_bidx == 3'd6) ? '0 : cur_bidx + 3'd1;
    nxt_baddr = (cur_bidx == 3'd6) ? cur_baddr + AW'(1) : cur_baddr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n_lat     <= '0;
      bidx      <= '0;
      baddr     <= '0;
      wren      <= '0;
      bank_addr <= '0;
      wr_real   <= '0;
      wr_imag   <= '0;
      cnt_sink  <= '0;
      sink_end  <= 1'b0;
      sink_err  <= 1'b0;
    end else begin
      wren     <= '0;
      sink_end <= 1'b0;
      sink_err <= 1'b0;

      if (accept) begin
        wren      <= 7'b1000000 >> cur_bidx;
        bank_addr <= cur_baddr;
        wr_real   <= in_real;
        wr_imag   <= in_imag;
      end

      // Leaving Sink still commits an accepted sample but drops all pulses.
      if (fsm != FSM_SINK) begin
        state    <= IDLE;
        cnt_sink <= '0;
        bidx     <= '0;
        baddr    <= '0;
      end else begin
        case (state)
          IDLE: state <= ARMED;
          ARMED, RECV: begin
            if (accept) begin
              n_lat <= cur_n;
              if (is_last) begin
                state    <= DONE;
                cnt_sink <= cur_n;
                sink_end <= 1'b1;
                sink_err <= !in_eop;
              end else if (short_eop) begin
                state    <= ARMED;
                cnt_sink <= '0;
                bidx     <= '0;
                baddr    <= '0;
                sink_err <= 1'b1;
              end else begin
                state    <= RECV;
                cnt_sink <= cur_idx + AW'(1);
                bidx     <= nxt_bidx;
                baddr    <= nxt_baddr;
                sink_err <= sop_take && (state == RECV);
              end
            end
          end
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
